// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, state enum and op-class helpers for mdu_iter
//
// Purpose: op codes, the control FSM state type and the decode helpers
//          used by the multiply/divide unit.
// Ports:   none (package).
package mdu_pkg;

  // Codes 10..15 are accepted as no-ops.
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op <= OP_MSUBU) && (op != OP_DIV) && (op != OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
//
// Purpose: shift the next dividend bit into the partial remainder and
//          subtract the divisor if it fits.
// Ports:
//   rem      in  WIDTH  partial remainder (always < divisor)
//   divisor  in  WIDTH  divisor magnitude
//   dvd_bit  in  1      next dividend bit, MSB first
//   rem_next out WIDTH  updated partial remainder
//   q_bit    out 1      quotient bit produced by this step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, dvd_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  // Either result is below the divisor, so the top bit is always zero.
  assign rem_next = WIDTH'(q_bit ? diff : shifted);

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Purpose: shift-add multiply (MUL_BITS per cycle) with MADD/MSUB accumulate,
//          restoring divide (one bit per cycle), MTHI/MTLO, flush support.
// Ports:
//   clk      in  1      clock, rising edge
//   RESET_N  in  1      asynchronous active-low reset
//   Req      in  1      exception pending, blocks new ops
//   Flush    in  1      abort in-flight op
//   Start    in  1      op valid
//   Op       in  4      op code (mdu_pkg)
//   A        in  WIDTH  rs operand
//   B        in  WIDTH  rt operand
//   RdSel    in  1      0 = HI, 1 = LO on HILO
//   Busy     out 1      op in flight
//   Done     out 1      pulse in the cycle after HI/LO take a result
//   HILO     out WIDTH  selected HI/LO register
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             Req,
  input  logic             Flush,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RdSel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HILO
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(WIDTH / MUL_BITS);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  // Multiply: product accumulator. Divide: {remainder, dividend/quotient}.
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  // Multiplier (shifted right each step) or divisor magnitude.
  logic [WIDTH-1:0] mplier;
  logic             neg_q;   // product / quotient negative
  logic             rneg_q;  // remainder negative (dividend sign)
  logic             dz_q;    // divide by zero early-out
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  assign accept = Start & ~Req & ~Flush & (state == ST_IDLE);
  assign a_neg  = is_signed(Op) & A[WIDTH-1];
  assign b_neg  = is_signed(Op) & B[WIDTH-1];
  // The most negative value maps to itself, which is its correct unsigned magnitude.
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign b_zero = (B == '0);

  // Shift-add: add the multiplicand once per set multiplier bit in this digit.
  logic [W2-1:0] partial;
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [W2-1:0]    acc_div_nxt;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[W2-1:WIDTH]),
    .divisor  (mplier),
    .dvd_bit  (acc[WIDTH-1]),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // Remainder in the upper half; quotient bits shift in as dividend bits shift out.
  assign acc_div_nxt = {rem_nxt, acc[WIDTH-2:0], q_bit};

  // Final sign fix-up and accumulate, evaluated in FIX.
  logic [W2-1:0]    prod;
  logic [W2-1:0]    fix_hilo;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] remv;
  always_comb begin
    prod     = neg_q ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    remv     = acc[W2-1:WIDTH];
    fix_hilo = prod;
    if (is_mul(op_q)) begin
      case (op_q)
        OP_MADD, OP_MADDU: fix_hilo = {hi, lo} + prod;
        OP_MSUB, OP_MSUBU: fix_hilo = {hi, lo} - prod;
        default:           fix_hilo = prod;
      endcase
    end else if (dz_q) begin
      // Raw dividend was parked in the low half.
      fix_hilo = {quo, {WIDTH{1'b1}}};
    end else begin
      fix_hilo = {(rneg_q ? -remv : remv), (neg_q ? -quo : quo)};
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (Op == OP_MTHI) begin
              hi <= A;
            end else if (Op == OP_MTLO) begin
              lo <= A;
            end else if (is_mul(Op)) begin
              state  <= ST_MUL;
              cnt    <= MUL_CNT;
              op_q   <= Op;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              rneg_q <= 1'b0;
              dz_q   <= 1'b0;
            end else if (is_div(Op)) begin
              state  <= ST_DIV;
              cnt    <= DIV_CNT;
              op_q   <= Op;
              acc    <= {{WIDTH{1'b0}}, (b_zero ? A : a_mag)};
              mcand  <= '0;
              mplier <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              dz_q   <= b_zero;
            end
          end
        end
        ST_MUL: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else if (dz_q) begin
            state <= ST_FIX;
          end else begin
            acc <= acc_div_nxt;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          // Flush outranks completion: drop the result silently.
          if (!Flush) begin
            hi     <= fix_hilo[W2-1:WIDTH];
            lo     <= fix_hilo[WIDTH-1:0];
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state != ST_IDLE);
  assign Done = done_q;
  assign HILO = RdSel ? lo : hi;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        Req;
  logic        Flush;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        RdSel;
  logic        Busy;
  logic        Done;
  logic [31:0] HILO;

  int n_pass  = 0;
  int n_total = 0;

  mdu_iter #(.WIDTH(32), .MUL_BITS(2)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .Req     (Req),
    .Flush   (Flush),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .RdSel   (RdSel),
    .Busy    (Busy),
    .Done    (Done),
    .HILO    (HILO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h;
    logic [31:0] l;
    RdSel = 1'b0;
    #1 h = HILO;
    RdSel = 1'b1;
    #1 l = HILO;
    check({tag, "_hi"}, h, exp_hi);
    check({tag, "_lo"}, l, exp_lo);
  endtask

  // Present an op and step past the edge that samples it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Op    = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  // Edges from the accept edge up to and including the one that raises Done.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!Done && lat < 200);
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (Done) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    RESET_N = 1'b0;
    Req     = 1'b0;
    Flush   = 1'b0;
    Start   = 1'b0;
    Op      = 4'd0;
    A       = '0;
    B       = '0;
    RdSel   = 1'b0;

    // Reset state
    #12;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check_hilo("rst", 32'h0, 32'h0);
    @(posedge clk);
    #1 RESET_N = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_rise", {31'b0, Busy}, 32'd1);
    wait_done(lat);
    check("mult_latency", lat, 32'd17);
    check("mult_busy_fall", {31'b0, Busy}, 32'd0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(posedge clk);
    #1 check("mult_done_single", {31'b0, Done}, 32'd0);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("div_latency", lat, 32'd33);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU by zero
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(lat);
    check("dz_latency", lat, 32'd2);
    check_hilo("dz", 32'h0000_0007, 32'hFFFF_FFFF);

    // Signed overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("ovf_latency", lat, 32'd33);
    check_hilo("ovf", 32'h0, 32'h8000_0000);

    // MT ops then MADDU / MSUB chain
    issue(OP_MTHI, 32'h0, 32'h0);
    check("mthi_busy", {31'b0, Busy}, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    check("mtlo_done", {31'b0, Done}, 32'd0);
    check_hilo("mt", 32'h0, 32'hFFFF_FFFF);
    issue(OP_MADDU, 32'd1, 32'd1);
    wait_done(lat);
    check("maddu_latency", lat, 32'd17);
    check_hilo("maddu", 32'h1, 32'h0);
    issue(OP_MSUB, 32'd1, 32'd2);
    wait_done(lat);
    check_hilo("msub", 32'h0, 32'hFFFF_FFFE);

    // Flush in MUL at cycle 10
    issue(OP_MULTU, 32'd5, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    check("flush_busy", {31'b0, Busy}, 32'd0);
    count_done(25, seen);
    check("flush_no_done", seen, 32'd0);
    check_hilo("flush", 32'h0, 32'hFFFF_FFFE);

    // Flush coinciding with FIX
    issue(OP_MULTU, 32'd9, 32'd9);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    check("flushfix_done", {31'b0, Done}, 32'd0);
    check("flushfix_busy", {31'b0, Busy}, 32'd0);
    check_hilo("flushfix", 32'h0, 32'hFFFF_FFFE);

    // Start with Req pending is ignored
    Req = 1'b1;
    issue(OP_MULT, 32'd4, 32'd4);
    Req = 1'b0;
    check("req_busy", {31'b0, Busy}, 32'd0);
    count_done(20, seen);
    check("req_no_done", seen, 32'd0);
    check_hilo("req", 32'h0, 32'hFFFF_FFFE);

    // MTLO issued in the Done cycle wins over the result
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done(lat);
    check_hilo("pre_mt", 32'h0, 32'h6);
    issue(OP_MTLO, 32'h55, 32'h0);
    check_hilo("mt_after_done", 32'h0, 32'h55);

    // Reset mid-divide
    issue(OP_MTHI, 32'h1234, 32'h0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    RESET_N = 1'b0;
    #1 check("midrst_busy", {31'b0, Busy}, 32'd0);
    check_hilo("midrst", 32'h0, 32'h0);
    @(posedge clk);
    #1 check("midrst_done", {31'b0, Done}, 32'd0);
    RESET_N = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: second MULT issued in the Done cycle
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done(lat);
    check_hilo("b2b_first", 32'h0, 32'h2A);
    issue(OP_MULT, 32'd3, 32'hFFFF_FFFC);
    check("b2b_accept", {31'b0, Busy}, 32'd1);
    wait_done(lat);
    check("b2b_latency", lat, 32'd17);
    check_hilo("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative, parametrised multiply/divide unit for the pipeline EX stage. It computes real shift-add products and restoring-division quotients over a configurable number of cycles, supports multiply-accumulate modes, and provides early-out for divide-by-zero. It owns the HI/LO architectural registers and supports flush of an in-flight operation when an exception is taken.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and at least 8.
- `MUL_BITS`, default 2: multiplier bits retired per cycle; allowed values are 1, 2 and 4; must divide `WIDTH`.
- `clk` in 1: system clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `Req` in 1: exception/interrupt pending; blocks acceptance of any new op.
- `Flush` in 1: aborts the in-flight op.
- `Start` in 1: op valid this cycle.
- `Op` in 4: operation code (see package).
- `A` in WIDTH: rs operand; multiplicand, dividend, or MTHI/MTLO data.
- `B` in WIDTH: rt operand; multiplier or divisor.
- `RdSel` in 1: read select; 0 selects HI, 1 selects LO.
- `Busy` out 1: an op is in flight.
- `Done` out 1: one-cycle pulse on the cycle HI/LO take a new result.
- `HILO` out WIDTH: `RdSel ? LO : HI`, combinational from the registers.

## Operation
- **Reset:** while `RESET_N` is low, state is IDLE. `Busy`, `Done`, HI, LO, the counter and the datapath registers are all 0.
- **Accept condition:** `Start & ~Req & ~Flush & ~Busy`. `Start` while `Busy` is ignored; the hazard unit stalls on `Busy`.
- **MTHI / MTLO:** write `A` into HI or LO at the accepting edge. No `Busy`, no `Done`.
- **MULT/MULTU/MADD/MADDU/MSUB/MSUBU:**
  - Signed ops take operand magnitudes, and the product sign is recorded.
  - The product is formed by shift-add, `MUL_BITS` per cycle, into a 2·WIDTH accumulator.
  - FIX cycle negates the product if the sign flag is set.
  - MADD: `{HI,LO} += P`. MSUB: `{HI,LO} -= P`. Both are modulo 2^(2·WIDTH).
- **DIV/DIVU:**
  - Restoring division, one quotient bit per cycle, on magnitudes.
  - FIX cycle applies signs: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - Result: LO = quotient, HI = remainder.
- **Divide by zero:** early-out. LO = all ones, HI = A.
- **Signed overflow** (A = most negative value, B = −1): LO = A, HI = 0, no exception.
- **FSM:**
  - IDLE → MUL or DIV on accept.
  - DIV → FIX directly when B = 0.
  - MUL/DIV → FIX when the counter reaches 1.
  - FIX → IDLE, writing HI/LO and pulsing `Done`.
- **Flush:**
  - In MUL, DIV or FIX: return to IDLE at the next edge, `Busy` = 0.
  - HI/LO keep their pre-op values, and no `Done` is produced.
  - `Flush` outranks FIX completion in the same cycle.
- **Req:** affects only acceptance; an in-flight op continues.

## Timing
- **Latency**, counted from the accept edge to the edge that writes HI/LO and sets `Done`:
  - Multiply class: WIDTH/MUL_BITS + 1 cycles; 17 for defaults.
  - Divide class: WIDTH + 1 cycles; 33 for defaults.
  - Divide by zero: 2 cycles (DIV, then FIX).
- `Busy` rises on the accept edge and falls on the completion edge. `Done` is high for exactly the cycle after the completion edge.
- Back-to-back: a new `Start` is accepted in the cycle `Done` is high.
- `HILO` reflects new values in the same cycle `Done` is high. A read while `Busy` returns the old HI/LO; the stall makes such reads illegal.
- An MT op in the cycle `Done` is high applies after the result, so the MT value wins.
- `RESET_N` asserted mid-op clears everything immediately, with no `Done`.

## Structure
- **Package `mdu_pkg`:**
  - 4-bit op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7, MTHI=8, MTLO=9. Codes 10–15 are no-ops.
  - State enum: IDLE, MUL, DIV, FIX.
  - Helper functions `is_signed(op)` and `is_mul(op)`.
- **Sub-module `mdu_div_step`:** combinational single restoring step, WIDTH-parametrised. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit.
- The multiply step stays inline in `mdu_iter`.

## Test plan
All cases use defaults (WIDTH=32, MUL_BITS=2).
- **Reset, then MULT:** MULT A=0xFFFFFFFE, B=3 → `Busy` for 17 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, single `Done` pulse.
- **Divide signs:** DIV A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1) after 33 cycles. DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7 after 2 cycles.
- **Signed overflow:** DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **MADD chain:** MTHI 0, MTLO 0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. Then MSUB A=1, B=2 → HI=0, LO=0xFFFFFFFE.
- **Flush:** MULTU started, `Flush` at cycle 10 → `Busy` low next cycle, HI/LO unchanged, no `Done`. `Start` with `Req`=1 → not accepted.
- **Reset mid-op:** `RESET_N` pulsed low during DIV → `Busy`=0, HI=LO=0 immediately. Back-to-back MULT issued in the `Done` cycle → accepted, completes 17 cycles later.
